// File: rtl/gpio_intr_ctrl_if.sv
// Register read/write bus between a CPU-side master and the GPIO interrupt controller.
interface gpio_intr_ctrl_if;
   logic [4:0] readaddr;
   logic [7:0] readdata;
   logic [4:0] writeaddr;
   logic [7:0] writedata;
   logic       write_en;

   modport master (output readaddr, writeaddr, writedata, write_en, input readdata);
   modport slave  (input readaddr, writeaddr, writedata, write_en, output readdata);
endinterface

// File: rtl/gpio_intr_ctrl.sv
// GPIO block: synchronized switches, debounced keys with per-key edge interrupts,
// LED register, and a small registered-read CPU register map.
module gpio_intr_ctrl #(
   parameter int unsigned NUM_KEYS        = 4,
   parameter int unsigned NUM_SW          = 4,
   parameter int unsigned NUM_LEDS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   gpio_intr_ctrl_if.slave       bus,
   output logic [7:0]            interrupts,
   input  logic [NUM_SW-1:0]     switches,
   input  logic [NUM_KEYS-1:0]   keys,
   output logic [NUM_LEDS-1:0]   leds
);

   typedef enum logic [4:0] {
      ADDR_SW   = 5'h00,
      ADDR_KEY  = 5'h01,
      ADDR_LED  = 5'h02,
      ADDR_PEND = 5'h03,
      ADDR_MASK = 5'h04,
      ADDR_ECFG = 5'h05
   } addr_e;

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0]   sw_meta_q, sw_sync_q;
   logic [NUM_KEYS-1:0] key_pressed_raw, key_meta_q, key_sync_q;
   logic [1:0]          start_q, start_d;
   logic [NUM_KEYS-1:0] arm_q, arm_d, deb_q, deb_d, ev;
   logic [NUM_KEYS-1:0] pend_q, pend_d, mask_q, mask_d, ecfg_q, ecfg_d;
   logic [15:0]         cnt_q [NUM_KEYS];
   logic [15:0]         cnt_d [NUM_KEYS];
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic [7:0]          rdata_q, rdata_d;

   // Keys are synchronized as "pressed" levels so a cleared synchronizer means released.
   assign key_pressed_raw = KEY_ACTIVE_LOW ? ~keys : keys;

   // A key only debounces after it has been seen released once since reset, so keys
   // held through reset raise no event; start_q skips the stale synchronizer contents.
   always_comb begin
      start_d = (start_q == 2'd2) ? start_q : start_q + 2'd1;
      arm_d   = arm_q;
      deb_d   = deb_q;
      ev      = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         cnt_d[i] = '0;
         if (!arm_q[i]) begin
            if (start_q == 2'd2 && !key_sync_q[i]) arm_d[i] = 1'b1;
         end else if (key_sync_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = key_sync_q[i];
               ev[i]    = key_sync_q[i] | ecfg_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      led_d  = led_q;
      mask_d = mask_q;
      ecfg_d = ecfg_q;
      pend_d = pend_q;
      if (bus.write_en) begin
         case (addr_e'(bus.writeaddr))
            ADDR_LED:  led_d  = bus.writedata[NUM_LEDS-1:0];
            ADDR_PEND: pend_d = pend_q & ~bus.writedata[NUM_KEYS-1:0];
            ADDR_MASK: mask_d = bus.writedata[NUM_KEYS-1:0];
            ADDR_ECFG: ecfg_d = bus.writedata[NUM_KEYS-1:0];
            default:   ;
         endcase
      end
      pend_d = pend_d | ev;
   end

   always_comb begin
      rdata_d = '0;
      case (addr_e'(bus.readaddr))
         ADDR_SW:   rdata_d = 8'(sw_sync_q);
         ADDR_KEY:  rdata_d = 8'(deb_q);
         ADDR_LED:  rdata_d = 8'(led_q);
         ADDR_PEND: rdata_d = 8'(pend_q);
         ADDR_MASK: rdata_d = 8'(mask_q);
         ADDR_ECFG: rdata_d = 8'(ecfg_q);
         default:   rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         key_meta_q <= '0;
         key_sync_q <= '0;
         start_q    <= '0;
         arm_q      <= '0;
         deb_q      <= '0;
         cnt_q      <= '{default: '0};
         led_q      <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         ecfg_q     <= '0;
         rdata_q    <= '0;
      end else begin
         sw_meta_q  <= switches;
         sw_sync_q  <= sw_meta_q;
         key_meta_q <= key_pressed_raw;
         key_sync_q <= key_meta_q;
         start_q    <= start_d;
         arm_q      <= arm_d;
         deb_q      <= deb_d;
         cnt_q      <= cnt_d;
         led_q      <= led_d;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         ecfg_q     <= ecfg_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign interrupts   = 8'(pend_q & mask_q);
   assign leds         = led_q;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// Directed bench for gpio_intr_ctrl: a sample-history model checked every cycle,
// plus literal expectations at the key scenario points.
module tb_gpio_intr_ctrl;
   localparam int D = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] switches = '0;
   logic [3:0] keys = 4'hF;
   logic [3:0] leds;
   logic [7:0] interrupts;

   int tests = 0;
   int fails = 0;

   gpio_intr_ctrl_if bus ();

   gpio_intr_ctrl #(
      .NUM_KEYS(4), .NUM_SW(4), .NUM_LEDS(4), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .interrupts(interrupts),
      .switches(switches), .keys(keys), .leds(leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: keeps pressed-level samples per edge; a key flips once the last D
   // synchronized samples (2 edges old) all differ from its debounced state.
   logic [3:0] kh [64];
   logic [3:0] sh [64];
   int         n;
   int         since [4];
   logic [3:0] m_deb, m_led, m_mask, m_ecfg, m_pend, m_arm, nd, ev, sw_now;
   logic [7:0] m_rd;
   logic       all_diff;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n = 0; m_deb = '0; m_led = '0; m_mask = '0; m_ecfg = '0; m_pend = '0; m_arm = '0;
         m_rd = '0;
         for (int i = 0; i < 4; i++) since[i] = 0;
      end else begin
         n++;
         kh[n % 64] = ~keys;
         sh[n % 64] = switches;
         sw_now = (n >= 3) ? sh[(n - 2) % 64] : 4'h0;
         case (bus.readaddr)
            5'h00:   m_rd = {4'h0, sw_now};
            5'h01:   m_rd = {4'h0, m_deb};
            5'h02:   m_rd = {4'h0, m_led};
            5'h03:   m_rd = {4'h0, m_pend};
            5'h04:   m_rd = {4'h0, m_mask};
            5'h05:   m_rd = {4'h0, m_ecfg};
            default: m_rd = 8'h00;
         endcase
         nd = m_deb;
         ev = '0;
         for (int i = 0; i < 4; i++) begin
            if (m_arm[i] && (n - since[i] + 1) >= D) begin
               all_diff = 1'b1;
               for (int j = 0; j < D; j++)
                  if (kh[(n - 2 - j) % 64][i] == m_deb[i]) all_diff = 1'b0;
               if (all_diff) begin
                  nd[i] = ~m_deb[i];
                  since[i] = n + 1;
                  if (nd[i] || m_ecfg[i]) ev[i] = 1'b1;
               end
            end
            if (!m_arm[i] && n >= 3 && kh[(n - 2) % 64][i] == 1'b0) begin
               m_arm[i] = 1'b1;
               since[i] = n + 1;
            end
         end
         if (bus.write_en) begin
            case (bus.writeaddr)
               5'h02:   m_led  = bus.writedata[3:0];
               5'h03:   m_pend = m_pend & ~bus.writedata[3:0];
               5'h04:   m_mask = bus.writedata[3:0];
               5'h05:   m_ecfg = bus.writedata[3:0];
               default: ;
            endcase
         end
         m_pend = m_pend | ev;
         m_deb  = nd;
      end
   end

   always @(negedge clk) begin
      check("leds", {4'h0, leds}, {4'h0, m_led});
      check("interrupts", interrupts, {4'h0, m_pend & m_mask});
      check("readdata", bus.readdata, m_rd);
   end

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      bus.write_en = 1'b1; bus.writeaddr = a; bus.writedata = d;
      @(negedge clk);
      bus.write_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
      bus.readaddr = a;
      @(negedge clk);
      check(name, bus.readdata, exp);
   endtask

   initial begin
      bus.readaddr = '0; bus.writeaddr = '0; bus.writedata = '0; bus.write_en = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_leds", {4'h0, leds}, 8'h00);
      check("reset_int", interrupts, 8'h00);
      check("reset_rdata", bus.readdata, 8'h00);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // key0 press: event lands on the 18th edge after the change
      keys = 4'b1110; bus.readaddr = 5'h03;
      repeat (18) @(negedge clk);
      check("pend_before_edge18", bus.readdata, 8'h00);
      @(negedge clk);
      check("pend_after_edge18", bus.readdata, 8'h01);
      check("int_masked", interrupts, 8'h00);
      rd(5'h01, 8'h01, "key_deb0");

      // key1 glitch of 10 cycles is rejected
      keys = 4'b1100;
      repeat (10) @(negedge clk);
      keys = 4'b1110;
      repeat (30) @(negedge clk);
      rd(5'h01, 8'h01, "key_glitch");
      rd(5'h03, 8'h01, "pend_glitch");

      wr(5'h04, 8'h0F);
      check("int_key0", interrupts, 8'h01);
      wr(5'h03, 8'h01);
      check("int_clr0", interrupts, 8'h00);
      keys = 4'b1010;
      repeat (25) @(negedge clk);
      check("int_key2", interrupts, 8'h04);
      wr(5'h03, 8'h00);
      check("w0_nochange", interrupts, 8'h04);
      wr(5'h03, 8'h04);
      check("w1c_key2", interrupts, 8'h00);
      keys = 4'b1111;
      repeat (25) @(negedge clk);
      rd(5'h03, 8'h00, "no_release_evt");
      rd(5'h01, 8'h00, "key_released");

      // both-edge key3: release event coincides with W1C
      wr(5'h05, 8'h08);
      keys = 4'b0111;
      repeat (25) @(negedge clk);
      rd(5'h03, 8'h08, "key3_press");
      wr(5'h03, 8'h08);
      check("key3_cleared", interrupts, 8'h00);
      keys = 4'b1111;
      repeat (17) @(negedge clk);
      wr(5'h03, 8'h08);
      check("set_wins", interrupts, 8'h08);
      rd(5'h03, 8'h08, "set_wins_rd");

      wr(5'h02, 8'hFF);
      check("leds_ff", {4'h0, leds}, 8'h0F);
      rd(5'h02, 8'h0F, "led_rd");
      rd(5'h1A, 8'h00, "unmapped_rd");
      wr(5'h1A, 8'hFF);
      wr(5'h00, 8'hFF);
      wr(5'h01, 8'hFF);
      rd(5'h00, 8'h00, "sw_ro");
      rd(5'h05, 8'h08, "ecfg_kept");
      switches = 4'hA;
      repeat (3) @(negedge clk);
      rd(5'h00, 8'h0A, "sw_sync");

      // reset mid-debounce with key1 held
      wr(5'h02, 8'h05);
      keys = 4'b1101;
      repeat (12) @(negedge clk);
      check("pre_rst_leds", {4'h0, leds}, 8'h05);
      check("pre_rst_int", interrupts, 8'h08);
      #2 reset_n = 1'b0;
      #1;
      check("rst_leds", {4'h0, leds}, 8'h00);
      check("rst_int", interrupts, 8'h00);
      check("rst_rdata", bus.readdata, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      rd(5'h01, 8'h00, "held_no_deb");
      rd(5'h03, 8'h00, "held_no_evt");
      keys = 4'b1111;
      repeat (25) @(negedge clk);
      keys = 4'b1101;
      repeat (25) @(negedge clk);
      rd(5'h01, 8'h02, "repress_deb");
      rd(5'h03, 8'h02, "repress_evt");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
